// File: rtl/reg_write_arbiter.sv
// Two-requester writeback arbiter for the 8x8 reg_file write port, with a per-register busy scoreboard.
// Define REGARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module reg_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       REQ0_VALID,
    input  logic [ADDR_WIDTH-1:0]      REQ0_ADDR,
    input  logic [DATA_WIDTH-1:0]      REQ0_DATA,
    output logic                       REQ0_READY,
    input  logic                       REQ1_VALID,
    input  logic [ADDR_WIDTH-1:0]      REQ1_ADDR,
    input  logic [DATA_WIDTH-1:0]      REQ1_DATA,
    output logic                       REQ1_READY,
    output logic [DATA_WIDTH-1:0]      WR_DATA,
    output logic [ADDR_WIDTH-1:0]      WR_ADDR,
    output logic                       WR_EN,
    output logic                       GRANT_ID,
    output logic [2**ADDR_WIDTH-1:0]   PENDING
);

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_REQ0,
        SEL_REQ1
    } sel_t;

    logic                  buf0_valid;
    logic [ADDR_WIDTH-1:0] buf0_addr;
    logic [DATA_WIDTH-1:0] buf0_data;
    logic                  buf1_valid;
    logic [ADDR_WIDTH-1:0] buf1_addr;
    logic [DATA_WIDTH-1:0] buf1_data;

    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  grant_id_q;

    sel_t                  sel;

`ifdef REGARB_RR_EN
    logic                  prio;
    logic                  contested;

    assign contested = buf0_valid && buf1_valid;
`endif

    always_comb begin
        sel = SEL_NONE;
        if (buf0_valid && buf1_valid) begin
`ifdef REGARB_RR_EN
            sel = prio ? SEL_REQ1 : SEL_REQ0;
`else
            sel = SEL_REQ0;
`endif
        end else if (buf0_valid) begin
            sel = SEL_REQ0;
        end else if (buf1_valid) begin
            sel = SEL_REQ1;
        end
    end

    // A buffer only accepts while empty, so a buffer being granted cannot refill in the same edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            buf0_valid <= 1'b0;
            buf0_addr  <= '0;
            buf0_data  <= '0;
            buf1_valid <= 1'b0;
            buf1_addr  <= '0;
            buf1_data  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= 1'b0;
`ifdef REGARB_RR_EN
            prio       <= 1'b0;
`endif
        end else begin
            if (!buf0_valid && REQ0_VALID) begin
                buf0_valid <= 1'b1;
                buf0_addr  <= REQ0_ADDR;
                buf0_data  <= REQ0_DATA;
            end else if (sel == SEL_REQ0) begin
                buf0_valid <= 1'b0;
            end

            if (!buf1_valid && REQ1_VALID) begin
                buf1_valid <= 1'b1;
                buf1_addr  <= REQ1_ADDR;
                buf1_data  <= REQ1_DATA;
            end else if (sel == SEL_REQ1) begin
                buf1_valid <= 1'b0;
            end

            wr_en_q <= (sel != SEL_NONE);
            if (sel == SEL_REQ0) begin
                wr_addr_q  <= buf0_addr;
                wr_data_q  <= buf0_data;
                grant_id_q <= 1'b0;
            end else if (sel == SEL_REQ1) begin
                wr_addr_q  <= buf1_addr;
                wr_data_q  <= buf1_data;
                grant_id_q <= 1'b1;
            end

`ifdef REGARB_RR_EN
            if (contested) begin
                prio <= (sel == SEL_REQ0);
            end
`endif
        end
    end

    always_comb begin
        PENDING = '0;
        for (int unsigned i = 0; i < 2**ADDR_WIDTH; i++) begin
            if ((buf0_valid && buf0_addr == ADDR_WIDTH'(i)) ||
                (buf1_valid && buf1_addr == ADDR_WIDTH'(i)) ||
                (wr_en_q    && wr_addr_q == ADDR_WIDTH'(i))) begin
                PENDING[i] = 1'b1;
            end
        end
    end

    assign REQ0_READY = ~buf0_valid;
    assign REQ1_READY = ~buf1_valid;
    assign WR_EN      = wr_en_q;
    assign WR_ADDR    = wr_addr_q;
    assign WR_DATA    = wr_data_q;
    assign GRANT_ID   = grant_id_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized traffic against a
// cycle-level model; honours REGARB_RR_EN the same way as the design.
module tb_reg_write_arbiter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       REQ0_VALID = 1'b0;
    logic [2:0] REQ0_ADDR = '0;
    logic [7:0] REQ0_DATA = '0;
    logic       REQ0_READY;
    logic       REQ1_VALID = 1'b0;
    logic [2:0] REQ1_ADDR = '0;
    logic [7:0] REQ1_DATA = '0;
    logic       REQ1_READY;
    logic [7:0] WR_DATA;
    logic [2:0] WR_ADDR;
    logic       WR_EN;
    logic       GRANT_ID;
    logic [7:0] PENDING;

    int compared = 0;
    int mismatched = 0;

    reg_write_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
        .WR_DATA(WR_DATA), .WR_ADDR(WR_ADDR), .WR_EN(WR_EN), .GRANT_ID(GRANT_ID), .PENDING(PENDING)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: each requester owns at most one queued write; the output stage is one slot.
    bit         q_full[2];
    logic [2:0] q_addr[2];
    logic [7:0] q_data[2];
    logic       m_en;
    logic [2:0] m_addr;
    logic [7:0] m_data;
    logic       m_gid;
    int         m_ptr;
    logic [7:0] m_regs[8];
    bit         model_ok = 0;

    always @(posedge CLK) begin
        int  w;
        bit  take[2];
        if (RESET) begin
            q_full[0] = 0; q_full[1] = 0;
            m_en = 0; m_addr = 0; m_data = 0; m_gid = 0; m_ptr = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (m_en) m_regs[m_addr] = m_data;
            take[0] = REQ0_VALID && !q_full[0];
            take[1] = REQ1_VALID && !q_full[1];
            w = -1;
            if (q_full[0] && q_full[1]) begin
`ifdef REGARB_RR_EN
                w = m_ptr;
                m_ptr = 1 - w;
`else
                w = 0;
`endif
            end else if (q_full[0]) w = 0;
            else if (q_full[1]) w = 1;
            m_en = (w >= 0);
            if (w >= 0) begin
                m_addr = q_addr[w];
                m_data = q_data[w];
                m_gid  = w[0];
                q_full[w] = 0;
            end
            if (take[0]) begin q_full[0] = 1; q_addr[0] = REQ0_ADDR; q_data[0] = REQ0_DATA; end
            if (take[1]) begin q_full[1] = 1; q_addr[1] = REQ1_ADDR; q_data[1] = REQ1_DATA; end
        end
    end

    function automatic logic [7:0] model_pending();
        logic [7:0] p = '0;
        for (int r = 0; r < 2; r++) if (q_full[r]) p[q_addr[r]] = 1'b1;
        if (m_en) p[m_addr] = 1'b1;
        return p;
    endfunction

    always @(negedge CLK) begin
        if (model_ok) begin
            chk("ready0", {31'b0, REQ0_READY}, {31'b0, !q_full[0]});
            chk("ready1", {31'b0, REQ1_READY}, {31'b0, !q_full[1]});
            chk("wr_en", {31'b0, WR_EN}, {31'b0, m_en});
            chk("wr_addr", {29'b0, WR_ADDR}, {29'b0, m_addr});
            chk("wr_data", {24'b0, WR_DATA}, {24'b0, m_data});
            if (m_en) chk("grant_id", {31'b0, GRANT_ID}, {31'b0, m_gid});
            chk("pending", {24'b0, PENDING}, {24'b0, model_pending()});
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        REQ0_VALID = 0;
        REQ1_VALID = 0;
    endtask

    task automatic do_reset();
        RESET = 1;
        idle();
        tick();
        RESET = 0;
    endtask

    task automatic expect_wr(input string name, input logic en, input logic [2:0] a,
                             input logic [7:0] d, input logic g);
        chk({name, "_en"}, {31'b0, WR_EN}, {31'b0, en});
        if (en) begin
            chk({name, "_addr"}, {29'b0, WR_ADDR}, {29'b0, a});
            chk({name, "_data"}, {24'b0, WR_DATA}, {24'b0, d});
            chk({name, "_gid"}, {31'b0, GRANT_ID}, {31'b0, g});
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        tick();

        // Reset state
        do_reset();
        chk("rst_ready0", {31'b0, REQ0_READY}, 32'd1);
        chk("rst_ready1", {31'b0, REQ1_READY}, 32'd1);
        expect_wr("rst", 1'b0, 3'd0, 8'h00, 1'b0);
        chk("rst_pending", {24'b0, PENDING}, 32'h00);
        chk("rst_gid", {31'b0, GRANT_ID}, 32'd0);
        chk("rst_wdata", {24'b0, WR_DATA}, 32'h00);

        // Single uncontested write
        REQ0_VALID = 1; REQ0_ADDR = 3'd1; REQ0_DATA = 8'hAA;
        tick();
        idle();
        chk("single_pend_n", {24'b0, PENDING}, 32'h02);
        chk("single_ready0", {31'b0, REQ0_READY}, 32'd0);
        expect_wr("single_n", 1'b0, 3'd0, 8'h00, 1'b0);
        tick();
        expect_wr("single_n1", 1'b1, 3'd1, 8'hAA, 1'b0);
        chk("single_pend_n1", {24'b0, PENDING}, 32'h02);
        tick();
        chk("single_en_off", {31'b0, WR_EN}, 32'd0);
        chk("single_hold", {24'b0, WR_DATA}, 32'hAA);
        chk("single_pend_clr", {24'b0, PENDING}, 32'h00);
        chk("single_reg1", {24'b0, m_regs[1]}, 32'hAA);

        // Contention, two rounds
        REQ0_VALID = 1; REQ0_ADDR = 3'd3; REQ0_DATA = 8'h55;
        REQ1_VALID = 1; REQ1_ADDR = 3'd5; REQ1_DATA = 8'hFF;
        tick();
        idle();
        chk("cont_ready1_a", {31'b0, REQ1_READY}, 32'd0);
        tick();
        expect_wr("cont1_first", 1'b1, 3'd3, 8'h55, 1'b0);
        chk("cont_ready1_b", {31'b0, REQ1_READY}, 32'd0);
        tick();
        expect_wr("cont1_second", 1'b1, 3'd5, 8'hFF, 1'b1);
        REQ0_VALID = 1; REQ0_ADDR = 3'd6; REQ0_DATA = 8'h66;
        REQ1_VALID = 1; REQ1_ADDR = 3'd7; REQ1_DATA = 8'h77;
        tick();
        idle();
        tick();
`ifdef REGARB_RR_EN
        expect_wr("cont2_first", 1'b1, 3'd7, 8'h77, 1'b1);
        tick();
        expect_wr("cont2_second", 1'b1, 3'd6, 8'h66, 1'b0);
`else
        expect_wr("cont2_first", 1'b1, 3'd6, 8'h66, 1'b0);
        tick();
        expect_wr("cont2_second", 1'b1, 3'd7, 8'h77, 1'b1);
`endif
        tick();

        // Same address from both requesters, pointer freshly reset
        do_reset();
        REQ0_VALID = 1; REQ0_ADDR = 3'd2; REQ0_DATA = 8'h11;
        REQ1_VALID = 1; REQ1_ADDR = 3'd2; REQ1_DATA = 8'h22;
        tick();
        idle();
        chk("same_pend0", {24'b0, PENDING}, 32'h04);
        tick();
        expect_wr("same_first", 1'b1, 3'd2, 8'h11, 1'b0);
        chk("same_pend1", {24'b0, PENDING}, 32'h04);
        tick();
        expect_wr("same_second", 1'b1, 3'd2, 8'h22, 1'b1);
        chk("same_pend2", {24'b0, PENDING}, 32'h04);
        tick();
        chk("same_pend3", {24'b0, PENDING}, 32'h00);
        chk("same_reg2", {24'b0, m_regs[2]}, 32'h22);

        // Reset while a write is still buffered
        REQ1_VALID = 1; REQ1_ADDR = 3'd4; REQ1_DATA = 8'h77;
        tick();
        RESET = 1;
        REQ1_VALID = 0;
        REQ0_VALID = 1; REQ0_ADDR = 3'd4; REQ0_DATA = 8'h99;
        tick();
        RESET = 0;
        idle();
        chk("midrst_en", {31'b0, WR_EN}, 32'd0);
        chk("midrst_pend", {24'b0, PENDING}, 32'h00);
        chk("midrst_ready1", {31'b0, REQ1_READY}, 32'd1);
        chk("midrst_ready0", {31'b0, REQ0_READY}, 32'd1);
        tick();
        chk("midrst_en2", {31'b0, WR_EN}, 32'd0);

        // req1 held valid while req0 keeps refilling
        REQ1_VALID = 1; REQ1_ADDR = 3'd5; REQ1_DATA = 8'hFF;
        for (int i = 0; i < 12; i++) begin
            REQ0_VALID = (i % 2 == 0);
            REQ0_ADDR  = 3'($urandom_range(0, 7));
            REQ0_DATA  = 8'($urandom);
            tick();
        end
        idle();
        tick();
        tick();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            RESET      = ($urandom_range(0, 249) == 0);
            REQ0_VALID = ($urandom_range(0, 99) < 60);
            REQ0_ADDR  = 3'($urandom_range(0, 7));
            REQ0_DATA  = 8'($urandom);
            REQ1_VALID = ($urandom_range(0, 99) < 55);
            REQ1_ADDR  = 3'($urandom_range(0, 7));
            REQ1_DATA  = 8'($urandom);
            tick();
        end
        RESET = 0;
        idle();
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
